// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // One buffered fetch: the address it came from and the returned word.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  // Sequential next-word address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetched {pc, instr} entries with flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output fq_entry_t     head,
  output logic [CW-1:0] cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fq_entry_t     mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          pop_ok_s;
  logic          push_ok_s;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // Qualify push/pop so a misbehaving caller can never under/overflow the ring.
  always_comb begin
    pop_ok_s  = pop && (cnt_r != CW'(0));
    push_ok_s = push && ((cnt_r != CW'(DEPTH)) || pop_ok_s);
  end

  // Entry storage; written at the tail on every accepted push.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; flush empties the ring in one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      cnt_r    <= CW'(0);
    end else if (flush) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      cnt_r    <= CW'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Head is read straight from storage; callers gate it with cnt.
  always_comb begin
    head = mem_r[rd_ptr_r];
    cnt  = cnt_r;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, request credits, stale-response discard
// and the in-order instruction queue feeding IF/ID.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               StallF,
  input  logic               RedirectValid,
  input  logic [31:0]        RedirectPC,
  output logic               IReq,
  output logic [31:0]        IAddr,
  input  logic               IGnt,
  input  logic               IRValid,
  input  logic [INSTR_W-1:0] IRData,
  output logic [INSTR_W-1:0] Instr,
  output logic [31:0]        PCPlus4F,
  output logic               InstrValidF,
  output logic               FetchBusy
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]   fpc_r;
  logic [31:0]   rpc_r;
  logic [CW-1:0] outst_r;
  logic [CW-1:0] discard_r;

  logic [CW-1:0] q_cnt_s;
  fq_entry_t     q_head_s;
  fq_entry_t     push_entry_s;
  logic          instr_valid_s;
  logic          pop_s;
  logic [CW:0]   occupancy_s;
  logic          ireq_s;
  logic          accept_s;
  logic          keep_s;

  // Consume, credit and keep/drop decisions for this cycle.
  always_comb begin
    instr_valid_s = (q_cnt_s != CW'(0));
    pop_s         = instr_valid_s && !StallF && !RedirectValid;
    // Credits freed by a same-cycle pop can be reused immediately.
    occupancy_s   = {1'b0, outst_r} + {1'b0, q_cnt_s} - (CW + 1)'(pop_s);
    ireq_s        = RST_N && !RedirectValid && (occupancy_s < (CW + 1)'(QDEPTH));
    accept_s      = ireq_s && IGnt;
    // A response is stale if older than the last redirect or racing one now.
    keep_s        = IRValid && (discard_r == CW'(0)) && !RedirectValid;
    push_entry_s  = '{pc: rpc_r, instr: IRData};
  end

  // Fetch PC: redirect reloads, each accepted request advances by one word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fpc_r <= RESET_PC;
    end else if (RedirectValid) begin
      fpc_r <= RedirectPC;
    end else if (accept_s) begin
      fpc_r <= pc_inc(fpc_r);
    end else begin
      fpc_r <= fpc_r;
    end
  end

  // PC of the next response to keep; tracks requests in order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rpc_r <= RESET_PC;
    end else if (RedirectValid) begin
      rpc_r <= RedirectPC;
    end else if (keep_s) begin
      rpc_r <= pc_inc(rpc_r);
    end else begin
      rpc_r <= rpc_r;
    end
  end

  // Outstanding request count: +1 on accept, -1 on any response.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      outst_r <= CW'(0);
    end else begin
      case ({accept_s, IRValid})
        2'b10:   outst_r <= outst_r + CW'(1);
        2'b01:   outst_r <= outst_r - CW'(1);
        default: outst_r <= outst_r;
      endcase
    end
  end

  // Stale-response counter: on redirect every still-pending response is stale.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      discard_r <= CW'(0);
    end else if (RedirectValid) begin
      discard_r <= outst_r - CW'(IRValid);
    end else if (IRValid && (discard_r != CW'(0))) begin
      discard_r <= discard_r - CW'(1);
    end else begin
      discard_r <= discard_r;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (keep_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (RedirectValid),
    .head      (q_head_s),
    .cnt       (q_cnt_s)
  );

  // Output presentation: NOP and zero PC+4 whenever the queue is empty.
  always_comb begin
    IReq        = ireq_s;
    IAddr       = fpc_r;
    InstrValidF = instr_valid_s;
    FetchBusy   = !instr_valid_s;
    if (instr_valid_s) begin
      Instr    = q_head_s.instr;
      PCPlus4F = pc_inc(q_head_s.pc);
    end else begin
      Instr    = NOP_INSTR;
      PCPlus4F = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-bench memory with random latency and
// grant, plus a queue-level model of what IF/ID must see each cycle.
module tb_fetch_unit;

  localparam int QD = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        StallF = 1'b0;
  logic        RedirectValid = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IGnt = 1'b0;
  logic        IRValid = 1'b0;
  logic [31:0] IRData = 32'h0;
  logic [31:0] Instr;
  logic [31:0] PCPlus4F;
  logic        InstrValidF;
  logic        FetchBusy;

  always #5 CLK = ~CLK;

  fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .QDEPTH   (QD)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .StallF        (StallF),
    .RedirectValid (RedirectValid),
    .RedirectPC    (RedirectPC),
    .IReq          (IReq),
    .IAddr         (IAddr),
    .IGnt          (IGnt),
    .IRValid       (IRValid),
    .IRData        (IRData),
    .Instr         (Instr),
    .PCPlus4F      (PCPlus4F),
    .InstrValidF   (InstrValidF),
    .FetchBusy     (FetchBusy)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        pend[$];   // requests accepted by memory, oldest first
  ent_t        mq[$];     // instructions the fetch queue must hold
  int          cyc = 0;
  int          epoch = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [31:0] fpc_m = 32'h0000_3000;
  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] s_iaddr;
  logic [31:0] s_instr;
  logic [31:0] s_pc4;
  logic        s_ireq;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance both.
  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc, input logic gnt);
    logic        resp;
    logic        exp_valid;
    logic        exp_pop;
    logic        exp_ireq;
    logic        acc;
    logic [31:0] acc_addr;
    int          occ;
    req_t        r;
    StallF        = stall;
    RedirectValid = redir;
    RedirectPC    = rpc;
    IGnt          = gnt;
    resp          = (pend.size() > 0) && (pend[0].ready <= cyc);
    IRValid       = resp;
    IRData        = resp ? mem_word(pend[0].addr) : $urandom;
    #1;
    exp_valid = (mq.size() > 0);
    exp_pop   = exp_valid && !stall && !redir;
    occ       = pend.size() + mq.size() - (exp_pop ? 1 : 0);
    exp_ireq  = !redir && (occ < QD);
    s_iaddr = IAddr;
    s_ireq  = IReq;
    s_instr = Instr;
    s_pc4   = PCPlus4F;
    check("IReq", 32'(IReq), 32'(exp_ireq));
    if (exp_ireq) check("IAddr", IAddr, fpc_m);
    check("InstrValidF", 32'(InstrValidF), 32'(exp_valid));
    check("FetchBusy", 32'(FetchBusy), 32'(!exp_valid));
    check("Instr", Instr, exp_valid ? mq[0].instr : 32'h0);
    check("PCPlus4F", PCPlus4F, exp_valid ? mq[0].pc + 32'd4 : 32'h0);
    check("credit_limit", 32'((pend.size() + mq.size()) <= QD), 32'd1);
    acc      = IReq && gnt;
    acc_addr = IAddr;
    if (exp_pop) void'(mq.pop_front());
    if (resp) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !redir) mq.push_back('{r.addr, mem_word(r.addr)});
    end
    if (redir) begin
      mq.delete();
      epoch++;
      fpc_m = rpc;
    end
    if (acc) begin
      pend.push_back('{acc_addr, epoch, cyc + int'($urandom_range(lat_hi, lat_lo))});
      if (!redir) fpc_m = fpc_m + 32'd4;
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  // Assert reset asynchronously, check reset outputs, clear memory and model.
  task automatic do_reset();
    RST_N = 1'b0;
    #2;
    check("rst_Instr", Instr, 32'h0);
    check("rst_PCPlus4F", PCPlus4F, 32'h0);
    check("rst_InstrValidF", 32'(InstrValidF), 32'd0);
    check("rst_FetchBusy", 32'(FetchBusy), 32'd1);
    pend.delete();
    mq.delete();
    epoch++;
    fpc_m = 32'h0000_3000;
    StallF = 1'b0;
    RedirectValid = 1'b0;
    IGnt = 1'b0;
    IRValid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Run until the queue presents something, then pin the head literally.
  task automatic wait_head(input string name, input logic [31:0] pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (InstrValidF) begin
        seen = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    check({name, "_arrived"}, 32'(seen), 32'd1);
    check({name, "_pc4"}, PCPlus4F, pc + 32'd4);
    check({name, "_instr"}, Instr, mem_word(pc));
  endtask

  initial begin
    logic [31:0] rnd;
    @(negedge CLK);
    do_reset();

    // Single-cycle memory, always granted: steady stream from 0x3000.
    lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 0) check("first_IAddr", s_iaddr, 32'h0000_3000);
      if (k == 1) check("second_IAddr", s_iaddr, 32'h0000_3004);
      if (k >= 2) begin
        check("stream_pc4", s_pc4, 32'h0000_3004 + 32'(4 * (k - 2)));
        check("stream_instr", s_instr, mem_word(32'h0000_3000 + 32'(4 * (k - 2))));
      end
    end

    // Four stall cycles mid-stream, then release.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (k == 3) check("stall_ireq_low", 32'(s_ireq), 32'd0);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to 0x4000 with two requests in flight, 3-cycle memory.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_4000, 1'b1);
    wait_head("redir4000", 32'h0000_4000);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect in the same cycle as a response (2-cycle memory, cycle 2).
    do_reset();
    lat_lo = 2; lat_hi = 2;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_5000, 1'b1);
    wait_head("redir5000", 32'h0000_5000);

    // Random grant, latency 1..5, stalls, redirects and one mid-stream reset.
    do_reset();
    lat_lo = 1; lat_hi = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_reset_IAddr", s_iaddr, 32'h0000_3000);
      end
      rnd = $urandom;
      step($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0,
           {rnd[29:0], 2'b00}, $urandom_range(9, 0) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage front end. Owns the fetch PC, issues requests to a variable-latency instruction memory, buffers returned instructions in a small in-order queue, and presents one instruction per cycle to the IF/ID pipeline register. It honours the hazard unit's fetch stall, discards in-flight fetches on a branch/jump redirect, and reports `FetchBusy` so decode stalls when no instruction is ready.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: first fetch address after reset.
- `QDEPTH`, default 2, legal 2..8: queue entries, which also equals the outstanding-request credit limit.

Ports:
- `CLK` input, 1: clock, rising edge.
- `RST_N` input, 1: asynchronous active-low reset.
- `StallF` input, 1: hazard unit holds fetch; head is not consumed.
- `RedirectValid` input, 1: branch/jump taken; restart fetching at `RedirectPC`.
- `RedirectPC` input, 32: new fetch address, word aligned.
- `IReq` output, 1: fetch request valid.
- `IAddr` output, 32: fetch address.
- `IGnt` input, 1: memory accepts the request this cycle (`IReq && IGnt`).
- `IRValid` input, 1: response data valid. One response per accepted request, in order, latency ≥1 cycle.
- `IRData` input, 32: returned instruction word.
- `Instr` output, 32: queue-head instruction; `32'h0` (NOP) when the queue is empty.
- `PCPlus4F` output, 32: head PC + 4; 0 when the queue is empty.
- `InstrValidF` output, 1: queue non-empty.
- `FetchBusy` output, 1: equals `!InstrValidF`; the hazard unit ORs it into `StallD`.

## Operation
- State: `fpc` (next fetch address), `outst` (accepted requests without a response), `discard` (stale responses still to drop, always ≤ `outst`), and the queue of {pc, instr} with occupancy `cnt`.
- Pop: `pop = InstrValidF && !StallF && !RedirectValid`. The IF/ID register captures `Instr` on the same edge.
- Issue: `IReq = !RedirectValid && (outst + cnt - pop < QDEPTH)`. `IAddr = fpc`. On accept, `fpc <= fpc + 4` and `outst` increments.
- Response: every `IRValid` decrements `outst`.
  - If `discard > 0`, or `RedirectValid` is high in the same cycle, the data is dropped and `discard` decrements when it is > 0.
  - Otherwise push {pc_of_request, `IRData`}. The request PC comes from a companion PC queue written on accept, or equivalently a `rpc` register that advances by 4 per kept response and is reloaded on redirect.
- Redirect (highest priority):
  - Queue flushed: `cnt <= 0`.
  - `fpc <= RedirectPC`.
  - `discard <= outst - IRValid`, so every remaining in-flight response is stale.
  - No issue and no pop that cycle.
- Invariant `outst + cnt ≤ QDEPTH`, so a push never overflows. Push and pop in the same cycle are legal at any occupancy, including a full queue.
- All counters are sized `$clog2(QDEPTH+1)` bits. `fpc` wraps modulo 2^32 with no trap.
- Reset (async, any time, including mid-transaction):
  - `fpc = RESET_PC`; `outst`, `discard` and `cnt` = 0.
  - `Instr = 0`, `PCPlus4F = 0`, `InstrValidF = 0`, `FetchBusy = 1`.
  - `IReq = 1` combinationally once `RST_N` is high.
  - Memory responses pending at reset are the memory's responsibility; memory shares `RST_N`.

## Timing
- Fetch-to-present latency is memory latency + 1. A response is registered into the queue and never bypassed to `Instr`.
- With 1-cycle memory, `IGnt` always 1 and no stall: the first instruction appears 2 cycles after reset release, then one instruction per cycle with no bubbles.
- `StallF` high: head held, `Instr`/`PCPlus4F` stable; issue continues until credits are exhausted.
- Redirect in cycle t: `Instr = 0` from t+1. The first redirected request issues at t+1, and its instruction appears at t+1+latency+1.
- `IReq`, `IAddr` and `Instr` have no combinational path from `IRValid`/`IRData`. `IReq` depends combinationally on `StallF` and `RedirectValid`.

## Structure
- Shared package `fetch_pkg`: `RESET_PC` default, `NOP_INSTR = 32'h0`, `INSTR_W = 32`, and struct `fq_entry_t` {pc[31:0], instr[31:0]}.
- One sub-module, `fetch_queue`: a circular FIFO of `fq_entry_t` with push, pop, flush, head, `cnt`, and async active-low reset. `fetch_unit` keeps the PC, credit and discard logic.

## Test plan
- Reset release, 1-cycle memory, `IGnt = 1`: `IAddr` sequence 0x3000, 0x3004, … one per cycle. `Instr` shows the matching words from cycle 2, with `PCPlus4F` 0x3004, 0x3008, ….
- `StallF` high for 4 cycles mid-stream: `Instr` held, `IReq` drops once `outst + cnt = 2`, no word lost or duplicated after release.
- Redirect to 0x4000 while 2 requests are outstanding with 3-cycle latency: both stale responses are dropped, `Instr = 0` until the word from 0x4000 arrives, and `PCPlus4F = 0x4004`.
- Redirect in the same cycle as `IRValid`: that response is dropped, and `discard` equals the remaining outstanding count.
- Random `IGnt` and latency 1..5 with random stalls: the instruction stream exactly equals memory contents in PC order, and `outst + cnt ≤ QDEPTH` always.
- `RST_N` asserted mid-stream: all outputs take reset values immediately, and fetching restarts at 0x3000.
